// File: rtl/negedge_skid_buffer_pkg.sv
// Shared state encoding and widths for the negedge skid buffer.
package negedge_skid_pkg;

   typedef logic [1:0] state_t;

   localparam state_t EMPTY = 2'd0;
   localparam state_t BUSY  = 2'd1;
   localparam state_t FULL  = 2'd2;

   localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/negedge_skid_buffer_if.sv
// Valid/ready handshake bundle: upstream in_* side and downstream out_* side.
interface negedge_skid_buffer_if #(
   parameter int size = 1
);
   logic            in_valid;
   logic            in_ready;
   logic [size-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [size-1:0] out_data;

   // slave is the buffer's view; master is the surrounding environment.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/negedge_skid_buffer_datareg.sv
// Enable-loaded data register, updated on negedge clk, async active-high clear.
module skid_datareg #(
   parameter int size = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [size-1:0] d,
   output logic [size-1:0] q
);
   logic [size-1:0] data_d;
   logic [size-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (en) begin
         data_d = d;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;
endmodule

// File: rtl/negedge_skid_buffer.sv
// Two-entry negedge skid buffer: 1-negedge latency, in_ready/out_valid decoded from state only.
// Optional NEGEDGE_SKID_STALL_EN adds a saturating 8-bit stall_cnt output.
module negedge_skid_buffer
   import negedge_skid_pkg::*;
#(
   parameter int size = 1
) (
   input  logic clk,
   input  logic rst,
   negedge_skid_buffer_if.slave bus
`ifdef NEGEDGE_SKID_STALL_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);
   state_t          state_d;
   state_t          state_q;
   logic            in_ready_w;
   logic            out_valid_w;
   logic            in_fire;
   logic            out_fire;
   logic            main_en;
   logic            main_sel_skid;
   logic            skid_en;
   logic [size-1:0] main_in;
   logic [size-1:0] main_out;
   logic [size-1:0] skid_out;

   // rst gates in_ready so it rises straight out of reset without a clock edge.
   assign in_ready_w  = ~rst & (state_q != FULL);
   assign out_valid_w = (state_q != EMPTY);
   assign in_fire     = bus.in_valid & in_ready_w;
   assign out_fire    = out_valid_w & bus.out_ready;

   always_comb begin
      state_d       = state_q;
      main_en       = 1'b0;
      main_sel_skid = 1'b0;
      skid_en       = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_en = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_en = 1'b1;
            end else if (in_fire) begin
               skid_en = 1'b1;
               state_d = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_en       = 1'b1;
               main_sel_skid = 1'b1;
               state_d       = BUSY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign main_in = main_sel_skid ? skid_out : bus.in_data;

   skid_datareg #(.size(size)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_in),
      .q   (main_out)
   );

   skid_datareg #(.size(size)) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (bus.in_data),
      .q   (skid_out)
   );

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_data  = main_out;

`ifdef NEGEDGE_SKID_STALL_EN
   logic [STALL_CNT_W-1:0] stall_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_w && !bus.out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_negedge_skid_buffer.sv
// Bench for negedge_skid_buffer (size=4): directed vector table, reset cases, random run vs queue model.
module tb_negedge_skid_buffer;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   negedge_skid_buffer_if #(.size(4)) bus ();

`ifdef NEGEDGE_SKID_STALL_EN
   logic [7:0] stall_cnt;
`endif

   negedge_skid_buffer #(.size(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef NEGEDGE_SKID_STALL_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Reference model: FIFO of accepted words, capacity two.
   logic [3:0] q[$];

   typedef struct {
      logic       iv;
      logic       ordy;
      logic [3:0] d;
      logic       e_rdy;
      logic       e_vld;
      logic [3:0] e_dat;
   } vec_t;

   vec_t vt[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One handshake cycle: drive after posedge, transfer at negedge, settle.
   task automatic cycle(input logic iv, input logic ordy, input logic [3:0] d);
      int pre;
      @(posedge clk);
      #1;
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      bus.in_data   = d;
      pre = q.size();
      @(negedge clk);
      if (ordy && pre > 0) void'(q.pop_front());
      if (iv && pre < 2) q.push_back(d);
      #1;
   endtask

   // Mid-cycle asynchronous reset pulse with checks during and right after it.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_rst_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_rst_in_ready"},  32'(bus.in_ready),  32'd0);
      check({tag, "_rst_out_data"},  32'(bus.out_data),  32'd0);
      q.delete();
      #1;
      rst = 1'b0;
      #1;
      check({tag, "_rel_in_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic       iv;
      logic       ordy;
      logic [3:0] d;
      logic       stalled;
      logic [3:0] prev;

      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_data   = '0;

      // Backpressure into FULL, then drain; then streaming 1,2,3.
      vt[0] = '{1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 4'hA};
      vt[1] = '{1'b1, 1'b0, 4'hB, 1'b0, 1'b1, 4'hA};
      vt[2] = '{1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 4'hA};
      vt[3] = '{1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 4'hB};
      vt[4] = '{1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 4'hC};
      vt[5] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'hC};
      vt[6] = '{1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1};
      vt[7] = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2};
      vt[8] = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3};
      vt[9] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h3};

      #6;
      do_reset("init");

      for (int i = 0; i < 10; i++) begin
         cycle(vt[i].iv, vt[i].ordy, vt[i].d);
         check($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vt[i].e_rdy));
         check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_vld));
         check($sformatf("vec%0d_out_data", i),  32'(bus.out_data),  32'(vt[i].e_dat));
      end

      // Reset while FULL must discard A and B.
      cycle(1'b1, 1'b0, 4'hA);
      cycle(1'b1, 1'b0, 4'hB);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      do_reset("full");
      cycle(1'b1, 1'b1, 4'h5);
      check("post_rst_out_valid", 32'(bus.out_valid), 32'd1);
      check("post_rst_out_data",  32'(bus.out_data),  32'h5);
      cycle(1'b0, 1'b1, 4'h0);
      check("post_rst_drain_valid", 32'(bus.out_valid), 32'd0);
      check("post_rst_drain_data",  32'(bus.out_data),  32'h5);

      // Random traffic against the queue model.
      for (int i = 0; i < 1000; i++) begin
         iv      = 1'($urandom_range(0, 1));
         ordy    = ($urandom_range(0, 3) != 0);
         d       = 4'($urandom);
         stalled = (q.size() > 0) && !ordy;
         prev    = bus.out_data;
         cycle(iv, ordy, d);
         check("rand_in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
         check("rand_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
         if (q.size() > 0) check("rand_out_data", 32'(bus.out_data), 32'(q[0]));
         if (stalled) check("rand_stall_stable", 32'(bus.out_data), 32'(prev));
      end

`ifdef NEGEDGE_SKID_STALL_EN
      do_reset("stall");
      check("stall_cnt_reset", 32'(stall_cnt), 32'd0);
      cycle(1'b1, 1'b0, 4'h7);
      for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 4'h0);
      check("stall_cnt_sat", 32'(stall_cnt), 32'd255);
      cycle(1'b0, 1'b0, 4'h0);
      check("stall_cnt_hold", 32'(stall_cnt), 32'd255);
      rst = 1'b1;
      #1;
      check("stall_cnt_clr", 32'(stall_cnt), 32'd0);
      rst = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/negedge_skid_buffer.md
NEGEDGE_SKID_BUFFER -- requirements
Module: negedge_skid_buffer

Interface
REQ-001 Parameter: size, default 1, data width in bits; legal range is 1 or more.
REQ-002 Port: clk  input  1  clock; all state updates occur on negedge clk.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: in_valid  input  1  upstream has data on in_data.
REQ-005 Port: in_ready  output  1  block can accept in_data this cycle.
REQ-006 Port: in_data  input  size  upstream data.
REQ-007 Port: out_valid  output  1  out_data holds valid data.
REQ-008 Port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-009 Port: out_data  output  size  oldest buffered data.

Function
REQ-010 Transfers SHALL be sampled on negedge clk: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-011 The block SHALL hold 2 entries (main, skid) and SHALL have 3 states: EMPTY, BUSY and FULL.
REQ-012 In EMPTY: out_valid=0 and in_ready=1; in_fire SHALL load main from in_data and go to BUSY.
REQ-013 In BUSY with in_fire and out_fire, main SHALL load in_data and the state SHALL stay BUSY.
REQ-014 In BUSY with in_fire and no out_fire, skid SHALL load in_data and the state SHALL go to FULL.
REQ-015 In BUSY with out_fire and no in_fire, the state SHALL go to EMPTY.
REQ-016 In BUSY with neither in_fire nor out_fire, the state SHALL hold.
REQ-017 In FULL: in_ready=0 and in_valid is ignored; out_fire SHALL copy skid into main and go to BUSY; otherwise the state SHALL hold.
REQ-018 out_valid SHALL be 1 in BUSY and FULL; out_data SHALL always drive main.
REQ-019 in_ready and out_valid SHALL be decoded from the state register only, with no combinational path from in_valid or out_ready.
REQ-020 Latency SHALL be 1 negedge: data accepted at negedge N SHALL be on out_data with out_valid=1 immediately after negedge N.
REQ-021 Data SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL NOT change.
REQ-023 Every bit of size SHALL pass unmodified; there is no arithmetic on data.

Reset
REQ-024 While rst=1: state=EMPTY, main=0, skid=0, out_valid=0, in_ready=0; no transfer is accepted.
REQ-025 in_ready SHALL rise to 1 when rst deasserts, without waiting for a clock edge.
REQ-026 A reset asserted in BUSY or FULL SHALL immediately discard all buffered entries.

Configuration
REQ-027 With macro NEGEDGE_SKID_STALL_EN defined, the block SHALL add output port stall_cnt (8 bits).
REQ-028 stall_cnt SHALL increment on each negedge with out_valid & !out_ready, SHALL saturate at 255, and SHALL reset to 0 on rst.
REQ-029 Without NEGEDGE_SKID_STALL_EN, the port and its counter SHALL be absent; behaviour is otherwise identical.

Structure
REQ-030 Package negedge_skid_pkg SHALL hold the state typedef (EMPTY, BUSY, FULL) and the constant STALL_CNT_W=8.
REQ-031 One sub-module, skid_datareg (negedge, enable-loaded, async-reset register of parameter size), SHALL be instantiated for main and for skid.

Verification
REQ-032 size=4; rst pulse mid-cycle -> out_valid=0, in_ready=0 during reset, in_ready=1 after release, out_data=4'h0.
REQ-033 out_ready=1, in_valid=1, data 1,2,3 on successive negedges -> out_data 1,2,3 one negedge later each; state stays BUSY.
REQ-034 out_ready=0, push 4'hA then 4'hB -> state FULL, in_ready=0; 4'hC offered is not accepted; raise out_ready -> A, then B out; C accepted after the first out_fire.
REQ-035 In FULL, rst asserted -> immediate EMPTY; next push 4'h5 -> out_data=5 after one negedge; A and B never appear.
REQ-036 Random in_valid/out_ready for 1000 cycles -> scoreboard order matches, no loss, out_data stable while stalled.
REQ-037 With NEGEDGE_SKID_STALL_EN, hold out_valid=1 and out_ready=0 for 300 negedges -> stall_cnt=255 and stays 255; rst -> 0.
